// File: rtl/itch_replace_decoder_wide.sv
// itch_replace_decoder_wide: ITCH Replace Order ('U') decoder taking BEAT_BYTES bytes per beat.
// Parses old/new order refs, shares and price into a valid/ready holding register with drop
// detection and framing-error reporting.
// Optional feature: define REPLACE_STATS_EN to add saturating stat_parsed/stat_invalid/
// stat_dropped counters.
module itch_replace_decoder_wide #(
  parameter int unsigned BEAT_BYTES  = 4,
  parameter logic [7:0]  MSG_TYPE    = 8'h55,
  parameter int unsigned MSG_LENGTH  = 27,
  parameter logic [3:0]  PARSED_TYPE = 4'd4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*BEAT_BYTES-1:0] data_in,
  input  logic                    valid_in,
  input  logic                    sop_in,
  input  logic                    out_ready,
  output logic                    replace_out_valid,
  output logic [3:0]              replace_parsed_type,
  output logic [63:0]             replace_old_order_ref,
  output logic [63:0]             replace_new_order_ref,
  output logic [31:0]             replace_shares,
  output logic [31:0]             replace_price,
  output logic                    replace_packet_invalid,
  output logic                    replace_drop
`ifdef REPLACE_STATS_EN
  ,
  output logic [15:0]             stat_parsed,
  output logic [15:0]             stat_invalid,
  output logic [15:0]             stat_dropped
`endif
);

  localparam int unsigned IDX_W       = $clog2(MSG_LENGTH + BEAT_BYTES);
  // Payload bytes 1..24; byte 1 sits in the most significant byte of the accumulator.
  localparam int unsigned FIELD_BYTES = 24;

  typedef enum logic [1:0] {StIdle, StParse, StSkip} state_e;

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d, beat_base;
  logic [8*FIELD_BYTES-1:0] acc_q, acc_d, hold_q, hold_d;
  logic                     hold_valid_q, hold_valid_d;
  logic                     invalid_q, drop_q, drop_d;
  logic                     sop_beat, type_ok, last_beat;
  logic                     start, capture, clear_acc, complete, invalid;

  assign sop_beat  = valid_in & sop_in;
  assign type_ok   = (data_in[7:0] == MSG_TYPE);
  // Final beat once the beat reaches byte MSG_LENGTH-1 (covers a partial last beat).
  assign last_beat = (32'(idx_q) + BEAT_BYTES) >= MSG_LENGTH;
  // A fresh sop always maps lane 0 to message byte 0.
  assign beat_base = start ? '0 : idx_q;

  // State register and byte counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: framing, capture enables, completion and framing errors
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    start     = 1'b0;
    capture   = 1'b0;
    clear_acc = 1'b0;
    complete  = 1'b0;
    invalid   = 1'b0;
    unique case (state_q)
      StIdle: start = sop_beat;
      StParse: begin
        if (!valid_in) begin
          invalid   = 1'b1;
          clear_acc = 1'b1;
          state_d   = StIdle;
          idx_d     = '0;
        end else if (sop_in) begin
          // Truncated message: report it and decode the new beat as a fresh sop.
          invalid = 1'b1;
          start   = 1'b1;
        end else begin
          capture = 1'b1;
          if (last_beat) begin
            complete = 1'b1;
            state_d  = StIdle;
            idx_d    = '0;
          end else begin
            idx_d = idx_q + IDX_W'(BEAT_BYTES);
          end
        end
      end
      StSkip: begin
        if (sop_beat) begin
          start = 1'b1;
        end else if (valid_in) begin
          if (last_beat) begin
            state_d = StIdle;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(BEAT_BYTES);
          end
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
    if (start) begin
      state_d   = type_ok ? StParse : StSkip;
      idx_d     = IDX_W'(BEAT_BYTES);
      clear_acc = 1'b1;
      capture   = type_ok;
    end
  end

  // Field accumulator: each lane drops its byte into the matching payload slot
  always_comb begin
    acc_d = clear_acc ? '0 : acc_q;
    if (capture) begin
      for (int unsigned k = 0; k < BEAT_BYTES; k++) begin
        if ((32'(beat_base) + k) >= 1 && (32'(beat_base) + k) <= FIELD_BYTES) begin
          acc_d[8*(FIELD_BYTES - (32'(beat_base) + k)) +: 8] = data_in[8*k +: 8];
        end
      end
    end
  end

  // Holding register handshake: accept frees the slot, a completion into a busy slot drops
  always_comb begin
    hold_valid_d = hold_valid_q & ~out_ready;
    hold_d       = hold_q;
    drop_d       = 1'b0;
    if (complete) begin
      if (hold_valid_d) begin
        drop_d = 1'b1;
      end else begin
        hold_valid_d = 1'b1;
        hold_d       = acc_d;
      end
    end
  end

  // Datapath and pulse registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q        <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      invalid_q    <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      invalid_q    <= invalid;
      drop_q       <= drop_d;
    end
  end

  // Output decode from the holding register
  always_comb begin
    replace_out_valid      = hold_valid_q;
    replace_parsed_type    = hold_valid_q ? PARSED_TYPE : 4'd0;
    replace_old_order_ref  = hold_q[191:128];
    replace_new_order_ref  = hold_q[127:64];
    replace_shares         = hold_q[63:32];
    replace_price          = hold_q[31:0];
    replace_packet_invalid = invalid_q;
    replace_drop           = drop_q;
  end

`ifdef REPLACE_STATS_EN
  logic [15:0] stat_parsed_q, stat_invalid_q, stat_dropped_q;

  // Saturating event counters, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_parsed_q  <= '0;
      stat_invalid_q <= '0;
      stat_dropped_q <= '0;
    end else begin
      if (complete && stat_parsed_q != 16'hFFFF) stat_parsed_q <= stat_parsed_q + 16'd1;
      if (invalid && stat_invalid_q != 16'hFFFF) stat_invalid_q <= stat_invalid_q + 16'd1;
      if (drop_d && stat_dropped_q != 16'hFFFF) stat_dropped_q <= stat_dropped_q + 16'd1;
    end
  end

  assign stat_parsed  = stat_parsed_q;
  assign stat_invalid = stat_invalid_q;
  assign stat_dropped = stat_dropped_q;
`endif

endmodule

// File: doc/itch_replace_decoder_wide.md
Name: itch_replace_decoder_wide

Overview:
- Parametrised, multi-byte-per-beat successor to the single-byte ITCH Replace Order ('U') decoder.
- Accepts BEAT_BYTES message bytes per cycle and tracks message framing explicitly.
- Parses old/new order refs, shares and price; presents the result through a valid/ready output holding register with drop detection.
- Sits beside the other per-type decoders on the shared ITCH beat bus, feeding the arbiter/order-book stage.

Parameters:
- BEAT_BYTES, 4, bytes per input beat (legal: 1, 2, 4, 8); lane 0 carries the lowest message byte index.
- MSG_TYPE, 8'h55, message type byte to match (ASCII 'U').
- MSG_LENGTH, 27, total message bytes including 2 reserved trailing bytes (minimum 25).
- PARSED_TYPE, 4'd4, code driven on replace_parsed_type.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset (resets while 0)
- data_in  in  8*BEAT_BYTES  beat data; lane k = data_in[8k+7:8k]
- valid_in  in  1  beat valid
- sop_in  in  1  beat carries message byte 0 in lane 0; qualified by valid_in
- out_ready  in  1  downstream accepts result
- replace_out_valid  out  1  result held and valid
- replace_parsed_type  out  4  PARSED_TYPE while out_valid, else 0
- replace_old_order_ref  out  64  bytes 1-8, big-endian
- replace_new_order_ref  out  64  bytes 9-16, big-endian
- replace_shares  out  32  bytes 17-20, big-endian
- replace_price  out  32  bytes 21-24, big-endian
- replace_packet_invalid  out  1  one-cycle pulse on framing error
- replace_drop  out  1  one-cycle pulse when a completed message is lost to backpressure

Behaviour:
- Reset (rst=0, async): state IDLE, byte_index 0; all outputs, field accumulators and holding register cleared to 0.
- byte_index counts message bytes consumed; +BEAT_BYTES per accepted beat. Width is clog2(MSG_LENGTH+BEAT_BYTES).
- Per beat, lane k holds message byte byte_index+k. Each field byte is captured from whichever lane carries it. Lanes with index >= MSG_LENGTH are ignored, as are reserved bytes 25..MSG_LENGTH-1.
- States:
  - IDLE:
    - valid_in&sop_in with lane0==MSG_TYPE -> PARSE; lanes 1..BEAT_BYTES-1 are captured in the same cycle.
    - valid_in&sop_in with lane0!=MSG_TYPE -> SKIP.
    - valid_in without sop_in -> ignored.
  - PARSE:
    - Each valid beat advances byte_index.
    - On the beat containing byte MSG_LENGTH-1 -> COMPLETE handling, then IDLE.
  - SKIP: consume beats until byte_index reaches MSG_LENGTH -> IDLE. No outputs change.
- Completion: the holding register loads the fields the cycle after the final beat, and replace_out_valid rises then (latency 1 after the last beat).
- Handshake:
  - out_valid stays high with stable fields until out_valid&out_ready; it clears the cycle after that.
  - If a completion occurs while the register is still held and not being accepted that cycle, the new result is discarded, replace_drop pulses, and the held data is unchanged.
  - Completion in the same cycle as acceptance loads the new result (no drop).
- Framing errors (PARSE only) pulse replace_packet_invalid for 1 cycle and discard partial fields:
  - valid_in=0 with 0<byte_index<MSG_LENGTH -> IDLE.
  - sop_in=1 before completion -> truncation; the new beat is treated as a fresh sop in that same cycle (PARSE or SKIP).
- SKIP ignores gaps; sop_in in SKIP restarts decode with no invalid pulse.
- Partial final beat (MSG_LENGTH not a multiple of BEAT_BYTES): completes on the beat where byte_index+BEAT_BYTES >= MSG_LENGTH.
- BEAT_BYTES=1 is cycle-equivalent to the legacy single-byte decoder except for the holding register.

Optional Feature:
- REPLACE_STATS_EN defined: adds outputs stat_parsed[15:0], stat_invalid[15:0], stat_dropped[15:0].
  - Each counter increments on completion, invalid pulse and drop pulse respectively.
  - Saturating at 16'hFFFF; cleared only by reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- BEAT_BYTES=4, one 'U' message as 7 beats (old=64'h0102030405060708, new=64'h1112131415161718, shares=32'h000003E8, price=32'h00989680), out_ready=1 -> out_valid 1 cycle after beat 7, fields exact, parsed_type=4, no invalid.
- Same message with out_ready=0, followed by a second 'U' (old=64'hA5) -> first result held stable, replace_drop pulses once at second completion; with REPLACE_STATS_EN, stat_dropped=1.
- valid_in dropped for 1 cycle after beat 3 -> packet_invalid pulses once, state IDLE; the next full message parses correctly.
- sop_in reasserted on beat 5 with a new 'U' -> packet_invalid pulse; the new message completes 7 beats after its sop with the new fields.
- Message with lane0=8'h41 ('A'), 27 bytes, then a 'U' -> no outputs for 'A'; 'U' result correct.
- BEAT_BYTES=1, MSG_LENGTH=27 -> out_valid 1 cycle after byte 26; rst driven low mid-PARSE clears all outputs immediately.
